// File: rtl/loader_pkg.sv
// Shared constants for the imem loader.
// State encodings and instruction word width.
package loader_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_W_HI   = 3'd3;
  localparam logic [2:0] S_W_LO   = 3'd4;
  localparam logic [2:0] S_CKSUM  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERR    = 3'd7;

  localparam int INSN_W = 16;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream imem loader: length, word pairs, XOR checksum.
// Holds the CPU until a verified image has been written.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INSN_W-1:0] imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc;
  logic [7:0]        xor_q, xor_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [INSN_W-1:0] wdata_q, wdata_d;
  logic [15:0]       n_val;
  logic              accept;

  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = in_valid & in_ready;

  // Stream-facing status decoded straight from the state register
  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b1;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_LEN_HI,
      S_LEN_LO,
      S_W_HI,
      S_W_LO,
      S_CKSUM: in_ready = 1'b1;
      S_DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
      end
      S_ERR:   error = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state, accumulator and write-port logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xor_d   = xor_q;
    len_d   = len_q;
    hi_d    = hi_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    n_val   = {len_q[15:8], in_data};
    case (state_q)
      S_IDLE,
      S_DONE,
      S_ERR: begin
        if (start) begin
          state_d = S_LEN_HI;
          cnt_d   = '0;
          xor_d   = '0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = in_data;
          xor_d       = xor_q ^ in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = n_val;
          xor_d = xor_q ^ in_data;
          if (n_val > 16'(DEPTH))
            state_d = S_ERR;
          else if (n_val == 16'd0)
            state_d = S_CKSUM;
          else
            state_d = S_W_HI;
        end
      end
      S_W_HI: begin
        if (accept) begin
          hi_d    = in_data;
          xor_d   = xor_q ^ in_data;
          state_d = S_W_LO;
        end
      end
      S_W_LO: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = {hi_q, in_data};
          cnt_d   = cnt_inc;
          xor_d   = xor_q ^ in_data;
          if (16'(cnt_inc) == len_q)
            state_d = S_CKSUM;
          else
            state_d = S_W_HI;
        end
      end
      S_CKSUM: begin
        if (accept) begin
          if (in_data == xor_q)
            state_d = S_DONE;
          else
            state_d = S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xor_q   <= '0;
      len_q   <= '0;
      hi_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xor_q   <= xor_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader.
// Reference model derives writes and outcome from the image format.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         expq[$];
  logic [7:0]  img[$];
  logic [15:0] wq[$];
  int          checks = 0;
  int          errors = 0;
  bit          rnd_valid = 0;
  bit          prev_we = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse pops one expected write
  always @(negedge clk) begin
    if (imem_we) begin
      checks++;
      if (prev_we) begin
        errors++;
        $display("FAIL we_back_to_back: got 1 want 0");
      end
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h",
                 imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          errors++;
          $display("FAIL write: got %0h/%0h want %0h/%0h",
                   imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
    prev_we = imem_we;
  end

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    if (rnd_valid) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready 0 want 1");
    end
  endtask

  task automatic make_image(input int n, input bit bad);
    logic [7:0] x;
    img = {};
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    foreach (wq[i]) begin
      img.push_back(wq[i][15:8]);
      img.push_back(wq[i][7:0]);
    end
    x = 8'h00;
    foreach (img[i]) x = x ^ img[i];
    img.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  // Model: writes and verdict from the image format alone
  task automatic run_image(input string tag, input bit mid_start);
    int n;
    int nsend;
    bit exp_ok;
    logic [7:0] x;
    n = {img[0], img[1]};
    if (n > 256) begin
      exp_ok = 0;
      nsend  = 2;
    end else begin
      x = 8'h00;
      for (int i = 0; i < 2 + 2 * n; i++) x = x ^ img[i];
      exp_ok = (img[2 + 2 * n] == x);
      nsend  = 3 + 2 * n;
      for (int i = 0; i < n; i++)
        expq.push_back({8'(i), img[2 + 2 * i], img[3 + 2 * i]});
    end
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      send_byte(img[i]);
      if (mid_start && i == 1) begin
        pulse_start();
        chk({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (done || error) break;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done), 32'(exp_ok));
    chk({tag, "_error"}, 32'(error), 32'(!exp_ok));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(!exp_ok));
    chk({tag, "_pending"}, 32'(expq.size()), 32'd0);
    expq = {};
  endtask

  task automatic img1(input bit bad);
    wq = {16'h2001, 16'h4C80, 16'hFFFF};
    make_image(3, bad);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(imem_wdata), 32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 32'd0);

    img1(0);
    run_image("img1", 0);
    img1(1);
    run_image("img1_badck", 0);

    wq = {};
    make_image(0, 0);
    run_image("n0_ok", 0);
    make_image(0, 1);
    run_image("n0_bad", 0);

    make_image(257, 0);
    run_image("n257", 0);

    wq = {};
    for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
    make_image(256, 0);
    run_image("n256", 0);

    rnd_valid = 1;
    img1(0);
    run_image("img1_rnd_start", 1);

    for (int k = 0; k < 6; k++) begin
      int n;
      n  = $urandom_range(1, 9);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(16'($urandom));
      make_image(n, ($urandom_range(0, 2) == 0));
      run_image("rand", 0);
    end
    rnd_valid = 0;

    expq.push_back({8'h00, 16'h2001});
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h20);
    send_byte(8'h01);
    send_byte(8'h4C);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_pending", 32'(expq.size()), 32'd0);
    expq = {};

    img1(0);
    run_image("after_rst", 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
